dsp_mac_seq: RTL and testbench

//  Sequencer that runs one DSP48A1 slice (proj_1, default register settings) as a signed dot-product engine.
//  It accepts a job length, streams operand pairs into slice A/B, and drives OPMODE/CE to clear-then-accumulate.

---
 rtl/dsp_mac_seq_if.sv | 31 +++
 rtl/dsp_mac_seq.sv | 144 ++++++++++++++
 tb/tb_dsp_mac_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_seq_if.sv
// Bundle between the dot-product sequencer, its sample/result client and the DSP48A1 slice.
// slave = sequencer side; master = client plus slice side.
interface dsp_mac_seq_if #(
  parameter int LEN_W = 8
);
  logic                     start;
  logic [LEN_W-1:0]         len;
  logic                     busy;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [17:0]       in_a;
  logic signed [17:0]       in_b;
  logic signed [17:0]       A;
  logic signed [17:0]       B;
  logic [7:0]               opmode;
  logic                     CE;
  logic signed [47:0]       P;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [47:0]       result;

  modport slave (
    input  start, len, in_valid, in_a, in_b, P, res_ready,
    output busy, in_ready, A, B, opmode, CE, res_valid, result
  );

  modport master (
    output start, len, in_valid, in_a, in_b, P, res_ready,
    input  busy, in_ready, A, B, opmode, CE, res_valid, result
  );
endinterface

// File: rtl/dsp_mac_seq.sv
// Runs one DSP48A1 slice as a signed dot-product engine: streams operand pairs,
// tags them clear/accumulate, drains the slice pipeline and returns the 48-bit sum.
module dsp_mac_seq #(
  parameter int LEN_W   = 8,
  parameter int LAT     = 3,
  parameter int OPM_DLY = 1
) (
  input  logic         clk,
  input  logic         RSTN,
  dsp_mac_seq_if.slave bus
);
  localparam int         DRAIN_N   = LAT + OPM_DLY;
  localparam int         DCW       = $clog2(DRAIN_N + 1);
  localparam logic [7:0] OPM_CLEAR = 8'h01;
  localparam logic [7:0] OPM_ACCUM = 8'h09;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   acc_cnt;
  logic [DCW-1:0]     drain_cnt;
  logic               first_seen;
  logic signed [17:0] a_p0;
  logic signed [17:0] b_p0;
  logic [7:0]         tag_p0 [OPM_DLY];
  logic [7:0]         opm_p1;
  logic signed [47:0] result_r;

  logic               in_ready;
  logic               accept;
  logic               last_accept;
  logic               drain_last;
  logic               slice_en;
  logic [7:0]         tag;

  always_comb begin
    state_nxt   = state;
    in_ready    = (state == RUN) && (acc_cnt < len_r);
    accept      = in_ready && bus.in_valid;
    last_accept = accept && ((acc_cnt + LEN_W'(1)) == len_r);
    drain_last  = (state == DRAIN) && (drain_cnt == DCW'(DRAIN_N - 1));
    slice_en    = (state == RUN) || (state == DRAIN);
    // Only the first accepted pair clears P; bubbles before it accumulate garbage that it discards.
    tag         = (accept && !first_seen) ? OPM_CLEAR : OPM_ACCUM;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (last_accept) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      len_r      <= '0;
      acc_cnt    <= '0;
      drain_cnt  <= '0;
      first_seen <= 1'b0;
      result_r   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            len_r      <= bus.len;
            acc_cnt    <= '0;
            drain_cnt  <= '0;
            first_seen <= 1'b0;
            result_r   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt    <= acc_cnt + LEN_W'(1);
            first_seen <= 1'b1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DCW'(1);
          // P already holds the last product one cycle before the final count.
          if (drain_last) begin
            result_r <= bus.P;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- p0: operand registers and tag delay line; p1: opmode register ----
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      a_p0   <= '0;
      b_p0   <= '0;
      opm_p1 <= '0;
      for (int i = 0; i < OPM_DLY; i++) begin
        tag_p0[i] <= '0;
      end
    end else if (slice_en) begin
      a_p0      <= accept ? bus.in_a : 18'sd0;
      b_p0      <= accept ? bus.in_b : 18'sd0;
      tag_p0[0] <= tag;
      for (int i = 1; i < OPM_DLY; i++) begin
        tag_p0[i] <= tag_p0[i-1];
      end
      opm_p1 <= tag_p0[OPM_DLY-1];
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.A         = a_p0;
  assign bus.B         = b_p0;
  assign bus.opmode    = opm_p1;
  assign bus.CE        = slice_en;
  assign bus.res_valid = (state == DONE);
  assign bus.result    = result_r;
endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq with a behavioural DSP48A1 slice (A1/B1, M, P and OPMODE registers).
module tb_dsp_mac_seq;
  logic clk  = 1'b0;
  logic RSTN = 1'b0;

  dsp_mac_seq_if #(.LEN_W(8)) bus ();

  dsp_mac_seq #(.LEN_W(8), .LAT(3), .OPM_DLY(1)) dut (
    .clk  (clk),
    .RSTN (RSTN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Slice model: X=M when opmode[1:0]==01, Z=P when opmode[3:2]==10, all stages gated by CE.
  logic signed [17:0] s_a1  = '0;
  logic signed [17:0] s_b1  = '0;
  logic [47:0]        s_m   = '0;
  logic [47:0]        s_p   = '0;
  logic [7:0]         s_opm = '0;

  always @(posedge clk) begin
    if (bus.CE) begin
      s_a1  <= bus.A;
      s_b1  <= bus.B;
      s_m   <= {{30{s_a1[17]}}, s_a1} * {{30{s_b1[17]}}, s_b1};
      s_opm <= bus.opmode;
      s_p   <= ((s_opm[3:2] == 2'b10) ? s_p : 48'd0) + ((s_opm[1:0] == 2'b01) ? s_m : 48'd0);
    end
  end
  assign bus.P = s_p;

  bit ce_watch = 1'b0;
  bit ce_seen  = 1'b0;
  always @(posedge clk) begin
    if (ce_watch && bus.CE) ce_seen <= 1'b1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic signed [17:0] va [8];
  logic signed [17:0] vb [8];
  logic [47:0]        j_res;
  int                 j_lat;
  bit                 rdy_after;

  // Called at posedge+1; returns once res_valid is seen (or the bound expires).
  task automatic run_job(input int n, input logic [15:0] stall, input bit valid_in_drain);
    int idx;
    int cyc;
    bit acc_now;
    idx       = 0;
    cyc       = 0;
    rdy_after = 1'b0;
    bus.start = 1'b1;
    bus.len   = 8'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = 8'hFF;
    while (idx < n && cyc < 100) begin
      bus.in_valid = (cyc < 16) ? !stall[cyc] : 1'b1;
      bus.in_a     = va[idx];
      bus.in_b     = vb[idx];
      acc_now      = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc_now) idx++;
      cyc++;
    end
    bus.in_valid = valid_in_drain;
    bus.in_a     = 18'sd1000;
    bus.in_b     = 18'sd1000;
    j_lat = 1;
    while (!bus.res_valid && j_lat < 50) begin
      if (bus.in_ready) rdy_after = 1'b1;
      @(posedge clk); #1;
      j_lat++;
    end
    if (bus.in_ready) rdy_after = 1'b1;
    bus.in_valid = 1'b0;
    j_res = bus.result;
  endtask

  task automatic finish_job();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {bus.busy, bus.in_ready, bus.res_valid, bus.CE}, 48'd0);
    check_eq("rst_A", bus.A, 48'd0);
    check_eq("rst_B", bus.B, 48'd0);
    check_eq("rst_opmode", bus.opmode, 48'd0);
    check_eq("rst_result", bus.result, 48'd0);
    RSTN = 1'b1;
    @(posedge clk); #1;

    // Back-to-back job, sum 2+4+6+8
    va[0] = 18'sd1; va[1] = 18'sd2; va[2] = 18'sd3; va[3] = 18'sd4;
    for (int i = 0; i < 4; i++) vb[i] = 18'sd2;
    run_job(4, 16'h0000, 1'b0);
    check_eq("t1_result", j_res, 48'd20);
    check_eq("t1_latency", 48'(j_lat), 48'd5);
    bus.start = 1'b1;
    bus.len   = 8'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("t1_busy_start_result", bus.result, 48'd20);
    check_eq("t1_busy_start_valid", bus.res_valid, 48'd1);
    finish_job();
    check_eq("t1_idle_after_hs", bus.busy, 48'd0);

    // Same job with stalls on cycles 0, 2, 3 and in_valid held high during drain
    run_job(4, 16'b0000_0000_0000_1101, 1'b1);
    check_eq("t2_result", j_res, 48'd20);
    check_eq("t2_latency", 48'(j_lat), 48'd5);
    check_eq("t2_ready_after_len", rdy_after, 48'd0);
    bus.res_ready = 1'b1;
    bus.start     = 1'b1;
    bus.len       = 8'd1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    check_eq("t2_start_on_hs_dropped", bus.busy, 48'd0);
    @(posedge clk); #1;
    check_eq("t2_still_idle", bus.busy, 48'd0);

    // Negative products, then full-scale positive with no carry-over from the prior job
    for (int i = 0; i < 3; i++) begin
      va[i] = -18'sd3;
      vb[i] = 18'sd5;
    end
    run_job(3, 16'h0000, 1'b0);
    check_eq("t3_neg_result", j_res, 48'hFFFF_FFFF_FFD3);
    finish_job();
    for (int i = 0; i < 2; i++) begin
      va[i] = 18'sd131071;
      vb[i] = 18'sd131071;
    end
    run_job(2, 16'h0000, 1'b0);
    check_eq("t3_fullscale_result", j_res, 48'h0007_FFF8_0002);
    finish_job();

    // Empty job: immediate zero result, slice never enabled, start while waiting ignored
    ce_seen   = 1'b0;
    ce_watch  = 1'b1;
    bus.start = 1'b1;
    bus.len   = 8'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("t4_valid_next_cycle", bus.res_valid, 48'd1);
    check_eq("t4_zero_result", bus.result, 48'd0);
    bus.start = 1'b1;
    bus.len   = 8'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("t4_ignored_start_valid", bus.res_valid, 48'd1);
    check_eq("t4_ignored_start_result", bus.result, 48'd0);
    check_eq("t4_ignored_start_in_ready", bus.in_ready, 48'd0);
    finish_job();
    ce_watch = 1'b0;
    check_eq("t4_ce_never", ce_seen, 48'd0);
    check_eq("t4_idle", bus.busy, 48'd0);

    // Asynchronous abort mid-RUN, then a fresh single-pair job
    bus.start = 1'b1;
    bus.len   = 8'd4;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = 18'sd9;
    bus.in_b     = 18'sd9;
    repeat (2) @(posedge clk);
    #2;
    RSTN = 1'b0;
    #1;
    check_eq("t5_abort_ctrl", {bus.busy, bus.in_ready, bus.res_valid, bus.CE}, 48'd0);
    check_eq("t5_abort_A", bus.A, 48'd0);
    check_eq("t5_abort_B", bus.B, 48'd0);
    check_eq("t5_abort_opmode", bus.opmode, 48'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    RSTN = 1'b1;
    @(posedge clk); #1;
    va[0] = 18'sd7;
    vb[0] = 18'sd6;
    run_job(1, 16'h0000, 1'b0);
    check_eq("t5_result", j_res, 48'd42);
    check_eq("t5_latency", 48'(j_lat), 48'd5);
    finish_job();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
